score_writer: RTL and testbench

- Bus-master side of the score peripheral's memory-mapped write port: keeps both players' scores and drives the single-cycle write strobe, 2-bit register address and 32-bit data into the score display controller.
- Scores are pushed only when they change, plus once after reset, so the display digit sprite always matches game state.
- Sits between game logic (scoring event pulses) and the graphic controller's score register file.

---
 rtl/score_pkg.sv | 16 +
 rtl/sat_counter.sv | 37 +++
 rtl/score_writer.sv | 172 +++++++++++++++++
 tb/tb_score_writer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared definitions for the score writer: bus width, register
// addresses of the score display controller and the write FSM states.
package score_pkg;

    localparam int BUS_W = 32;

    localparam logic [1:0] ADDR_SCORE1 = 2'b00;
    localparam logic [1:0] ADDR_SCORE2 = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR1  = 2'd1,
        WR2  = 2'd2
    } wr_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear, one per player.
// count_next exposes the value the counter takes at the next edge so the
// parent can register outputs that line up with the updated score.
module sat_counter #(
    parameter int W   = 4,
    parameter int MAX = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    // Clear wins over increment; increments stop at MAX.
    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (inc && (count != MAX_V)) begin
            count_next = count + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/score_writer.sv
// Score writer: keeps both players' scores and pushes each changed score
// to the score display controller as a single-cycle register write.
// Both registers are written once after reset and after every clear.
// Optional feature macro SCORE_REFRESH_EN adds a periodic forced re-write
// of both registers every REFRESH_CYCLES clocks.
module score_writer
    import score_pkg::*;
#(
    parameter int MAX_SCORE = 9,
    parameter int SCORE_W   = 4
`ifdef SCORE_REFRESH_EN
    ,
    parameter int REFRESH_CYCLES = 1000000
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               point1_i,
    input  logic               point2_i,
    input  logic               clear_i,
    output logic               MW_o,
    output logic [1:0]         address_o,
    output logic [BUS_W-1:0]   data_o,
    output logic [SCORE_W-1:0] score1_o,
    output logic [SCORE_W-1:0] score2_o,
    output logic               game_over_o
);

    localparam logic [SCORE_W-1:0] MAX_V = SCORE_W'(MAX_SCORE);

    wr_state_t          state;
    wr_state_t          state_next;
    logic               mw_next;
    logic [1:0]         addr_next;
    logic [BUS_W-1:0]   data_next;

    logic               pend1;
    logic               pend2;
    logic               accept1;
    logic               accept2;
    logic               refresh_wrap;
    logic [SCORE_W-1:0] score1_next;
    logic [SCORE_W-1:0] score2_next;

    // Points count only while the game is running and no clear is taking priority.
    assign accept1 = point1_i & ~game_over_o & ~clear_i;
    assign accept2 = point2_i & ~game_over_o & ~clear_i;

    sat_counter #(
        .W   (SCORE_W),
        .MAX (MAX_SCORE)
    ) u_score1 (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear_i),
        .inc        (accept1),
        .count      (score1_o),
        .count_next (score1_next)
    );

    sat_counter #(
        .W   (SCORE_W),
        .MAX (MAX_SCORE)
    ) u_score2 (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear_i),
        .inc        (accept2),
        .count      (score2_o),
        .count_next (score2_next)
    );

`ifdef SCORE_REFRESH_EN
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    logic [RW-1:0] refresh_cnt;

    assign refresh_wrap = (refresh_cnt == RW'(REFRESH_CYCLES - 1));

    // Free-running refresh timer, restarted by a new game.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
        end else if (clear_i || refresh_wrap) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end
`else
    assign refresh_wrap = 1'b0;
`endif

    // Game over is taken from the next score values so it rises together with the final score.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            game_over_o <= 1'b0;
        end else begin
            game_over_o <= (score1_next == MAX_V) || (score2_next == MAX_V);
        end
    end

    // Pending-write flags: a new change re-arms the flag even in the cycle its write completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend1 <= 1'b1;
            pend2 <= 1'b1;
        end else begin
            if (clear_i || accept1 || refresh_wrap) begin
                pend1 <= 1'b1;
            end else if (state == WR1) begin
                pend1 <= 1'b0;
            end
            if (clear_i || accept2 || refresh_wrap) begin
                pend2 <= 1'b1;
            end else if (state == WR2) begin
                pend2 <= 1'b0;
            end
        end
    end

    // Next state and next bus values; data uses the score that will be current during the write.
    always_comb begin
        state_next = state;
        mw_next    = 1'b0;
        addr_next  = address_o;
        data_next  = data_o;
        case (state)
            IDLE: begin
                if (pend1) begin
                    state_next = WR1;
                end else if (pend2) begin
                    state_next = WR2;
                end
            end
            WR1: begin
                state_next = pend2 ? WR2 : IDLE;
            end
            WR2: begin
                state_next = pend1 ? WR1 : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (state_next == WR1) begin
            mw_next   = 1'b1;
            addr_next = ADDR_SCORE1;
            data_next = {{(BUS_W - SCORE_W){1'b0}}, score1_next};
        end else if (state_next == WR2) begin
            mw_next   = 1'b1;
            addr_next = ADDR_SCORE2;
            data_next = {{(BUS_W - SCORE_W){1'b0}}, score2_next};
        end
    end

    // State and registered bus outputs; reset drops the strobe immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            MW_o      <= 1'b0;
            address_o <= 2'b00;
            data_o    <= '0;
        end else begin
            state     <= state_next;
            MW_o      <= mw_next;
            address_o <= addr_next;
            data_o    <= data_next;
        end
    end

endmodule

// File: tb/tb_score_writer.sv
// Self-checking bench for score_writer. Expected bus writes (address,
// data, cycle) are queued when stimulus is issued and a negedge monitor
// pops and compares each write the DUT presents. With SCORE_REFRESH_EN
// the monitor instead checks each write against the tracked scores and
// counts refresh writes.
module tb_score_writer;

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        point1_i;
    logic        point2_i;
    logic        clear_i;
    logic        MW_o;
    logic [1:0]  address_o;
    logic [31:0] data_o;
    logic [3:0]  score1_o;
    logic [3:0]  score2_o;
    logic        game_over_o;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   m1       = 0;
    int   m2       = 0;
    bit   mgo      = 0;
    int   w0       = 0;
    int   w1       = 0;

`ifdef SCORE_REFRESH_EN
    score_writer #(
        .MAX_SCORE      (9),
        .SCORE_W        (4),
        .REFRESH_CYCLES (16)
    ) dut (
`else
    score_writer #(
        .MAX_SCORE (9),
        .SCORE_W   (4)
    ) dut (
`endif
        .clk         (clk),
        .rst         (rst),
        .point1_i    (point1_i),
        .point2_i    (point2_i),
        .clear_i     (clear_i),
        .MW_o        (MW_o),
        .address_o   (address_o),
        .data_o      (data_o),
        .score1_o    (score1_o),
        .score2_o    (score2_o),
        .game_over_o (game_over_o)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Monitor: compare every write strobe seen on the bus
    always @(negedge clk) begin
        if (!rst && MW_o) begin
`ifdef SCORE_REFRESH_EN
            checks++;
            if (address_o == 2'b00) begin
                w0++;
                if (data_o != 32'(m1)) begin
                    failures++;
                    $display("[TB] FAIL write_s1 @%0d: data=%0d expected=%0d", cyc, data_o, m1);
                end
            end else if (address_o == 2'b01) begin
                w1++;
                if (data_o != 32'(m2)) begin
                    failures++;
                    $display("[TB] FAIL write_s2 @%0d: data=%0d expected=%0d", cyc, data_o, m2);
                end
            end else begin
                failures++;
                $display("[TB] FAIL write_addr @%0d: addr=%0d expected 0 or 1", cyc, address_o);
            end
`else
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_write @%0d: addr=%0d data=%0d expected no write",
                         cyc, address_o, data_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (address_o != e.addr || data_o != e.data || cyc != e.cyc) begin
                    failures++;
                    $display("[TB] FAIL write: got addr=%0d data=%0d cycle=%0d, expected addr=%0d data=%0d cycle=%0d",
                             address_o, data_o, cyc, e.addr, e.data, e.cyc);
                end
            end
`endif
        end
    end

    task automatic pushWrite(input logic [1:0] a, input int d, input int c);
        exp_t e;
        e.addr = a;
        e.data = 32'(d);
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // One-cycle pulse on the chosen inputs; t returns the cycle the pulse was high
    task automatic applyStimulus(input logic p1, input logic p2, input logic clr, output int t);
        @(posedge clk);
        #1;
        t        = cyc;
        point1_i = p1;
        point2_i = p2;
        clear_i  = clr;
        @(posedge clk);
        #1;
        point1_i = 1'b0;
        point2_i = 1'b0;
        clear_i  = 1'b0;
        if (clr) begin
            m1 = 0;
            m2 = 0;
        end else if (!mgo) begin
            if (p1 && m1 < 9) m1++;
            if (p2 && m2 < 9) m2++;
        end
        mgo = (m1 == 9) || (m2 == 9);
    endtask

    task automatic checkValue(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string name, input int s1, input int s2, input int go);
        checkValue({name, "_score1"}, int'(score1_o), s1);
        checkValue({name, "_score2"}, int'(score2_o), s2);
        checkValue({name, "_game_over"}, int'(game_over_o), go);
    endtask

    // Directed stimulus sequence
    initial begin
        int t;
        int t2;
        int r;
        rst      = 1'b1;
        point1_i = 1'b0;
        point2_i = 1'b0;
        clear_i  = 1'b0;
        idle(3);
        #1;
        checkOutput("reset", 0, 0, 0);
        checkValue("reset_mw", int'(MW_o), 0);
        checkValue("reset_addr", int'(address_o), 0);
        checkValue("reset_data", int'(data_o), 0);

        @(posedge clk);
        #1;
        rst = 1'b0;
        r   = cyc;
        pushWrite(2'b00, 0, r + 1);
        pushWrite(2'b01, 0, r + 2);
        idle(5);

`ifdef SCORE_REFRESH_EN
        repeat (3) begin
            applyStimulus(1'b1, 1'b0, 1'b0, t);
            idle(3);
        end
        repeat (4) begin
            applyStimulus(1'b0, 1'b1, 1'b0, t);
            idle(3);
        end
        idle(20);
        #1;
        checkOutput("refresh_scores", 3, 4, 0);
        @(posedge clk);
        #1;
        w0 = 0;
        w1 = 0;
        idle(64);
        #1;
        checkValue("refresh_count_s1", w0, 4);
        checkValue("refresh_count_s2", w1, 4);
`else
        applyStimulus(1'b1, 1'b0, 1'b0, t);
        pushWrite(2'b00, 1, t + 2);
        idle(4);
        checkOutput("single_p1", 1, 0, 0);

        applyStimulus(1'b1, 1'b1, 1'b0, t);
        pushWrite(2'b00, 2, t + 2);
        pushWrite(2'b01, 1, t + 3);
        idle(4);
        checkOutput("dual", 2, 1, 0);

        applyStimulus(1'b0, 1'b0, 1'b1, t);
        pushWrite(2'b00, 0, t + 2);
        pushWrite(2'b01, 0, t + 3);
        idle(4);
        checkOutput("clear1", 0, 0, 0);

        for (int k = 1; k <= 9; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, t);
            pushWrite(2'b01, k, t + 2);
            idle(3);
        end
        checkOutput("max2", 0, 9, 1);

        applyStimulus(1'b0, 1'b1, 1'b0, t);
        idle(4);
        checkOutput("sat2", 0, 9, 1);

        applyStimulus(1'b1, 1'b0, 1'b0, t);
        idle(4);
        checkOutput("gated_p1", 0, 9, 1);

        applyStimulus(1'b0, 1'b0, 1'b1, t);
        pushWrite(2'b00, 0, t + 2);
        pushWrite(2'b01, 0, t + 3);
        idle(4);
        checkOutput("clear_go", 0, 0, 0);

        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, t);
            pushWrite(2'b00, k, t + 2);
            idle(3);
        end
        checkOutput("five", 5, 0, 0);

        applyStimulus(1'b1, 1'b0, 1'b1, t);
        pushWrite(2'b00, 0, t + 2);
        pushWrite(2'b01, 0, t + 3);
        idle(4);
        checkOutput("clear_prio", 0, 0, 0);

        applyStimulus(1'b1, 1'b0, 1'b0, t);
        pushWrite(2'b00, 1, t + 2);
        applyStimulus(1'b1, 1'b0, 1'b0, t2);
        pushWrite(2'b00, 2, t2 + 2);
        idle(4);
        checkValue("rewrite_gap", t2 - t, 2);
        checkOutput("rewrite", 2, 0, 0);

        applyStimulus(1'b0, 1'b1, 1'b0, t);
        @(posedge clk);
        #2;
        checkValue("midwrite_mw_before", int'(MW_o), 1);
        rst = 1'b1;
        #1;
        checkValue("midwrite_mw_after", int'(MW_o), 0);
        checkOutput("midwrite_reset", 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        r   = cyc;
        pushWrite(2'b00, 0, r + 1);
        pushWrite(2'b01, 0, r + 2);
        idle(5);

        idle(100);
        checkValue("missing_writes", sb.size(), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
